// File: rtl/proto245a_burst_if.sv
// proto245a_burst_if
//   Bundles the FT245 async-FIFO pins and the two on-chip streams that
//   proto245a_burst connects to.
//   master modport : the protocol core (drives strobes, ft_dout, rx stream, tx_ready)
//   slave  modport : the FT chip and the stream users (drive flags, ft_din, tx stream)
//   Signals:
//     ft_rxfn/ft_txen        FT RXF#/TXE# flags (active low)
//     ft_din/ft_dout/ft_doe  data bus input, output and output enable
//     ft_rdn/ft_wrn/ft_siwun FT RD#/WR#/SIWU# strobes (active low)
//     rx_data/rx_valid/rx_ready  received word stream
//     tx_data/tx_valid/tx_ready  transmit word stream
//     tx_flush               one-cycle send-immediate request
interface proto245a_burst_if #(
  parameter int DATA_W = 8
);
  logic              ft_rxfn;
  logic              ft_txen;
  logic [DATA_W-1:0] ft_din;
  logic [DATA_W-1:0] ft_dout;
  logic              ft_doe;
  logic              ft_rdn;
  logic              ft_wrn;
  logic              ft_siwun;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_flush;

  modport master (
    input  ft_rxfn, ft_txen, ft_din, rx_ready, tx_data, tx_valid, tx_flush,
    output ft_dout, ft_doe, ft_rdn, ft_wrn, ft_siwun, rx_data, rx_valid, tx_ready
  );

  modport slave (
    output ft_rxfn, ft_txen, ft_din, rx_ready, tx_data, tx_valid, tx_flush,
    input  ft_dout, ft_doe, ft_rdn, ft_wrn, ft_siwun, rx_data, rx_valid, tx_ready
  );
endinterface

// File: rtl/proto245a_burst.sv
// proto245a_burst
//   FT245-style asynchronous FIFO protocol master. Moves single words between
//   the FT chip and the rx/tx valid/ready streams, with fair RX/TX burst
//   arbitration, SIWU# send-immediate flushes and an explicit data output
//   enable. No internal buffering.
//   Ports:
//     ft_clk  single clock
//     ft_rst  synchronous active-high reset
//     bus     proto245a_burst_if.master (FT pins + rx/tx streams + tx_flush)
module proto245a_burst #(
  parameter int DATA_W           = 8,
  parameter int READ_TICKS       = 4,
  parameter int WRITE_TICKS      = 4,
  parameter int SIWU_TICKS       = 4,
  parameter int TURNAROUND_TICKS = 8,
  parameter int BURST_LEN        = 16,
  parameter int SYNC_STAGES      = 2
) (
  input logic               ft_clk,
  input logic               ft_rst,
  proto245a_burst_if.master bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_TICKS = max2(max2(READ_TICKS, WRITE_TICKS),
                                  max2(SIWU_TICKS, TURNAROUND_TICKS));
  localparam int TICK_W = $clog2(MAX_TICKS + 1);
  localparam int BCNT_W = $clog2(BURST_LEN + 1);

  // Down-counters are loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [TICK_W-1:0] READ_LOAD  = TICK_W'(READ_TICKS - 1);
  localparam logic [TICK_W-1:0] WRITE_LOAD = TICK_W'(WRITE_TICKS - 1);
  localparam logic [TICK_W-1:0] SIWU_LOAD  = TICK_W'(SIWU_TICKS - 1);
  localparam logic [TICK_W-1:0] TA_LOAD    = TICK_W'(TURNAROUND_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
  localparam logic [BCNT_W-1:0] BURST_MAX  = BCNT_W'(BURST_LEN);
  localparam logic [BCNT_W-1:0] BCNT_ONE   = BCNT_W'(1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RX       = 3'd1;
  localparam logic [2:0] ST_TX_SETUP = 3'd2;
  localparam logic [2:0] ST_TX       = 3'd3;
  localparam logic [2:0] ST_SIWU     = 3'd4;
  localparam logic [2:0] ST_TA       = 3'd5;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  logic [2:0]             state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [SYNC_STAGES-1:0] rxfn_sync_q, rxfn_sync_d;
  logic [SYNC_STAGES-1:0] txen_sync_q, txen_sync_d;
  logic [DATA_W-1:0]      din_q, din_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   doe_q, doe_d;
  logic                   rdn_q, rdn_d;
  logic                   wrn_q, wrn_d;
  logic                   siwun_q, siwun_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   flush_pending_q, flush_pending_d;
  logic [BCNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic                   last_dir_q, last_dir_d;

  logic ft_not_empty, ft_not_full;
  logic rx_req, tx_req, fl_req;
  logic sel_valid, sel_dir;
  logic in_idle, start_rx, start_tx;

  // Flag synchronisers: stage 0 samples the pin, each later stage the previous one.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign rxfn_sync_d[gi] = bus.ft_rxfn;
      assign txen_sync_d[gi] = bus.ft_txen;
    end else begin : g_rest
      assign rxfn_sync_d[gi] = rxfn_sync_q[gi-1];
      assign txen_sync_d[gi] = txen_sync_q[gi-1];
    end
  end

  assign ft_not_empty = !rxfn_sync_q[SYNC_STAGES-1];
  assign ft_not_full  = !txen_sync_q[SYNC_STAGES-1];

  assign rx_req = ft_not_empty && !rx_valid_q;
  assign tx_req = ft_not_full && bus.tx_valid;
  assign fl_req = flush_pending_q;

  // Direction choice; only acted on in IDLE and only when no flush is pending.
  // With both sides requesting, stay on last_dir until BURST_LEN transactions
  // have gone that way, then hand over to the other side.
  always_comb begin
    sel_valid = 1'b0;
    sel_dir   = DIR_RX;
    if (rx_req && tx_req) begin
      sel_valid = 1'b1;
      sel_dir   = (burst_cnt_q < BURST_MAX) ? last_dir_q : ~last_dir_q;
    end else if (rx_req) begin
      sel_valid = 1'b1;
      sel_dir   = DIR_RX;
    end else if (tx_req) begin
      sel_valid = 1'b1;
      sel_dir   = DIR_TX;
    end
  end

  assign in_idle  = (state_q == ST_IDLE);
  assign start_rx = in_idle && !fl_req && sel_valid && (sel_dir == DIR_RX);
  assign start_tx = in_idle && !fl_req && sel_valid && (sel_dir == DIR_TX);

  // The tx word is taken on the same edge that moves IDLE -> TX_SETUP.
  assign bus.tx_ready = start_tx && !ft_rst;

  always_comb begin
    state_d         = state_q;
    tick_d          = tick_q;
    din_d           = bus.ft_din;
    dout_d          = dout_q;
    doe_d           = doe_q;
    rdn_d           = rdn_q;
    wrn_d           = wrn_q;
    siwun_d         = siwun_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    flush_pending_d = flush_pending_q;
    burst_cnt_d     = burst_cnt_q;
    last_dir_d      = last_dir_q;

    if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    // Burst accounting for a newly started data transaction (SIWU leaves it alone).
    if (start_rx || start_tx) begin
      if (sel_dir == last_dir_q) begin
        if (burst_cnt_q < BURST_MAX) begin
          burst_cnt_d = burst_cnt_q + BCNT_ONE;
        end
      end else begin
        burst_cnt_d = BCNT_ONE;
        last_dir_d  = sel_dir;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (fl_req) begin
          state_d         = ST_SIWU;
          siwun_d         = 1'b0;
          tick_d          = SIWU_LOAD;
          flush_pending_d = 1'b0;
        end else if (start_rx) begin
          state_d = ST_RX;
          rdn_d   = 1'b0;
          tick_d  = READ_LOAD;
        end else if (start_tx) begin
          state_d = ST_TX_SETUP;
          dout_d  = bus.tx_data;
          doe_d   = 1'b1;
        end
      end
      ST_RX: begin
        if (tick_q == '0) begin
          rx_data_d  = din_q;
          rx_valid_d = 1'b1;
          rdn_d      = 1'b1;
          state_d    = ST_TA;
          tick_d     = TA_LOAD;
        end else begin
          tick_d = tick_q - TICK_ONE;
        end
      end
      ST_TX_SETUP: begin
        state_d = ST_TX;
        wrn_d   = 1'b0;
        tick_d  = WRITE_LOAD;
      end
      ST_TX: begin
        if (tick_q == '0) begin
          wrn_d   = 1'b1;
          state_d = ST_TA;
          tick_d  = TA_LOAD;
        end else begin
          tick_d = tick_q - TICK_ONE;
        end
      end
      ST_SIWU: begin
        if (tick_q == '0) begin
          siwun_d = 1'b1;
          state_d = ST_TA;
          tick_d  = TA_LOAD;
        end else begin
          tick_d = tick_q - TICK_ONE;
        end
      end
      ST_TA: begin
        // Entering TA from TX leaves doe at 1, so data is held one extra cycle.
        doe_d = 1'b0;
        if (tick_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tick_d = tick_q - TICK_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rdn_d   = 1'b1;
        wrn_d   = 1'b1;
        siwun_d = 1'b1;
        doe_d   = 1'b0;
      end
    endcase

    // A new request always wins, even on the cycle the flag is cleared.
    if (bus.tx_flush) begin
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge ft_clk) begin
    if (ft_rst) begin
      state_q         <= ST_IDLE;
      tick_q          <= '0;
      rxfn_sync_q     <= '1;
      txen_sync_q     <= '1;
      din_q           <= '0;
      dout_q          <= '0;
      doe_q           <= 1'b0;
      rdn_q           <= 1'b1;
      wrn_q           <= 1'b1;
      siwun_q         <= 1'b1;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      flush_pending_q <= 1'b0;
      burst_cnt_q     <= '0;
      last_dir_q      <= DIR_RX;
    end else begin
      state_q         <= state_d;
      tick_q          <= tick_d;
      rxfn_sync_q     <= rxfn_sync_d;
      txen_sync_q     <= txen_sync_d;
      din_q           <= din_d;
      dout_q          <= dout_d;
      doe_q           <= doe_d;
      rdn_q           <= rdn_d;
      wrn_q           <= wrn_d;
      siwun_q         <= siwun_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      flush_pending_q <= flush_pending_d;
      burst_cnt_q     <= burst_cnt_d;
      last_dir_q      <= last_dir_d;
    end
  end

  assign bus.ft_dout  = dout_q;
  assign bus.ft_doe   = doe_q;
  assign bus.ft_rdn   = rdn_q;
  assign bus.ft_wrn   = wrn_q;
  assign bus.ft_siwun = siwun_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_proto245a_burst.sv
// tb_proto245a_burst
//   Directed bench for proto245a_burst (BURST_LEN=3, other parameters default).
//   A monitor logs every strobe pulse (kind, start cycle, length, data) and the
//   stream handshakes; the main sequence compares them to hand-computed values.
module tb_proto245a_burst;

  localparam int K_RX = 1;
  localparam int K_TX = 2;
  localparam int K_SW = 3;

  typedef struct {
    int kind;
    int start;
    int len;
    int data;
  } tr_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  proto245a_burst_if #(.DATA_W(8)) bus ();

  proto245a_burst #(.BURST_LEN(3)) dut (
    .ft_clk (clk),
    .ft_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s = 0x%0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  // Main sequence acts at negedge+2; the tx source at negedge; the monitor at negedge+3.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  tr_t  tr_q[$];
  logic [7:0] rxq[$];
  logic [7:0] txacc[$];
  logic [7:0] txq[$];
  int rxv_cycles = 0, txr_cycles = 0;
  int dout_bad = 0, doe_bad = 0, ovl_bad = 0;
  int doe_rise_cyc = 0, doe_rise_data = 0, doe_fall_cyc = 0;

  task automatic wait_log(input int n, input string tag);
    int k;
    k = 0;
    while (tr_q.size() < n && k < 2000) begin
      step(1);
      k++;
    end
    chk(tag, int'(tr_q.size() >= n), 1);
  endtask

  // which: 0 = RD#, 1 = WR#, 2 = SIWU#
  task automatic wait_low(input int which, input string tag);
    int k;
    logic lo;
    k = 0;
    lo = 1'b0;
    while (!lo && k < 2000) begin
      lo = (which == 0) ? !bus.ft_rdn : (which == 1) ? !bus.ft_wrn : !bus.ft_siwun;
      if (!lo) begin
        step(1);
        k++;
      end
    end
    chk(tag, int'(lo), 1);
  endtask

  // Strobe / handshake monitor.
  initial begin
    logic p_rdn, p_wrn, p_sw, p_doe;
    int rd_s, wr_s, sw_s, wr_d;
    p_rdn = 1'b1; p_wrn = 1'b1; p_sw = 1'b1; p_doe = 1'b0;
    rd_s = 0; wr_s = 0; sw_s = 0; wr_d = 0;
    forever begin
      @(negedge clk);
      #3;
      if (!bus.ft_rdn && p_rdn) rd_s = cyc;
      if (bus.ft_rdn && !p_rdn) tr_q.push_back('{K_RX, rd_s, cyc - rd_s, 0});
      if (!bus.ft_wrn && p_wrn) begin
        wr_s = cyc;
        wr_d = int'(bus.ft_dout);
      end
      if (!bus.ft_wrn) begin
        if (int'(bus.ft_dout) != wr_d) dout_bad++;
        if (!bus.ft_doe) doe_bad++;
      end
      if (bus.ft_wrn && !p_wrn) tr_q.push_back('{K_TX, wr_s, cyc - wr_s, wr_d});
      if (!bus.ft_siwun && p_sw) sw_s = cyc;
      if (bus.ft_siwun && !p_sw) tr_q.push_back('{K_SW, sw_s, cyc - sw_s, 0});
      if ((int'(!bus.ft_rdn) + int'(!bus.ft_wrn) + int'(!bus.ft_siwun)) > 1) ovl_bad++;
      if (!bus.ft_rdn && bus.ft_doe) ovl_bad++;
      if (bus.ft_doe && !p_doe) begin
        doe_rise_cyc  = cyc;
        doe_rise_data = int'(bus.ft_dout);
      end
      if (!bus.ft_doe && p_doe) doe_fall_cyc = cyc;
      if (bus.rx_valid) rxv_cycles++;
      if (bus.rx_valid && bus.rx_ready) rxq.push_back(bus.rx_data);
      if (bus.tx_ready) txr_cycles++;
      if (bus.tx_ready && bus.tx_valid) txacc.push_back(bus.tx_data);
      p_rdn = bus.ft_rdn; p_wrn = bus.ft_wrn; p_sw = bus.ft_siwun; p_doe = bus.ft_doe;
    end
  end

  // TX stream source: presents words from txq one at a time.
  initial begin
    logic acc_prev;
    acc_prev = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (acc_prev) begin
        if (txq.size() > 0) begin
          bus.tx_data  = txq.pop_front();
          bus.tx_valid = 1'b1;
        end else begin
          bus.tx_valid = 1'b0;
        end
      end else if (!bus.tx_valid && txq.size() > 0) begin
        bus.tx_data  = txq.pop_front();
        bus.tx_valid = 1'b1;
      end
      #4;
      acc_prev = bus.tx_valid && bus.tx_ready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, b, base, r, nb;
    int exp_k[10];
    exp_k = '{K_RX, K_RX, K_RX, K_TX, K_TX, K_TX, K_RX, K_RX, K_RX, K_TX};

    rst = 1'b1;
    bus.ft_rxfn  = 1'b1;
    bus.ft_txen  = 1'b1;
    bus.ft_din   = 8'h00;
    bus.rx_ready = 1'b1;
    bus.tx_flush = 1'b0;
    txq.push_back(8'h3C);
    step(3);

    // ---- reset state (tx_valid is already high) ----
    chk("rst_rdn", bus.ft_rdn, 1);
    chk("rst_wrn", bus.ft_wrn, 1);
    chk("rst_siwun", bus.ft_siwun, 1);
    chk("rst_doe", bus.ft_doe, 0);
    chk("rst_dout", bus.ft_dout, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_tx_ready", bus.tx_ready, 0);
    rst = 1'b0;
    step(6);
    chk("idle_no_txn", tr_q.size(), 0);
    chk("idle_no_tx_ready", txr_cycles, 0);

    // ---- RX single word, then a second one to measure turnaround ----
    bus.ft_din  = 8'hA5;
    bus.ft_rxfn = 1'b0;
    c0 = cyc;
    wait_log(1, "rx1_done");
    chk("rx1_kind", tr_q[0].kind, K_RX);
    chk("rx1_latency", tr_q[0].start - c0, 3);
    chk("rx1_len", tr_q[0].len, 4);
    bus.ft_din = 8'h5A;
    wait_low(0, "rx2_start");
    bus.ft_rxfn = 1'b1;
    wait_log(2, "rx2_done");
    chk("rx_gap", tr_q[1].start - (tr_q[0].start + tr_q[0].len), 9);
    step(15);
    chk("rx_words", rxq.size(), 2);
    chk("rx_word0", rxq[0], 8'hA5);
    chk("rx_word1", rxq[1], 8'h5A);
    chk("rx_valid_cycles", rxv_cycles, 2);

    // ---- TX single word (0x3C queued since reset) ----
    bus.ft_txen = 1'b0;
    wait_log(3, "tx_done");
    step(2);
    chk("tx_kind", tr_q[2].kind, K_TX);
    chk("tx_len", tr_q[2].len, 4);
    chk("tx_data", tr_q[2].data, 8'h3C);
    chk("tx_accepts", txacc.size(), 1);
    chk("tx_ready_cycles", txr_cycles, 1);
    chk("tx_doe_rise", doe_rise_cyc, tr_q[2].start - 1);
    chk("tx_doe_rise_data", doe_rise_data, 8'h3C);
    chk("tx_doe_fall", doe_fall_cyc - (tr_q[2].start + tr_q[2].len), 1);
    step(15);
    chk("tx_no_more", tr_q.size(), 3);

    // ---- back-pressure ----
    bus.rx_ready = 1'b0;
    bus.ft_rxfn  = 1'b0;
    wait_log(4, "bp_rx_done");
    step(40);
    chk("bp_single", tr_q.size(), 4);
    chk("bp_rx_valid_held", bus.rx_valid, 1);
    chk("bp_rx_data", bus.rx_data, 8'h5A);
    bus.rx_ready = 1'b1;
    b = cyc;
    wait_log(5, "bp_resume_done");
    bus.ft_rxfn = 1'b1;
    chk("bp_resume_kind", tr_q[4].kind, K_RX);
    chk("bp_resume_start", tr_q[4].start - b, 2);
    step(15);
    chk("bp_total", tr_q.size(), 5);
    chk("bp_rx_words", rxq.size(), 4);

    // ---- arbitration from reset, both directions busy ----
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    base = tr_q.size();
    for (int i = 0; i < 6; i++) txq.push_back(8'(8'h10 + i));
    bus.ft_rxfn = 1'b0;
    wait_log(base + 10, "arb_done");
    bus.ft_rxfn = 1'b1;
    for (int i = 0; i < 10; i++) chk($sformatf("arb_kind%0d", i), tr_q[base + i].kind, exp_k[i]);
    step(60);
    chk("arb_total", tr_q.size(), base + 12);
    chk("arb_tx_drained", int'(bus.tx_valid), 0);
    chk("arb_last_word", txacc[txacc.size() - 1], 8'h15);

    // ---- flush during TX, second flush during SIWU ----
    base = tr_q.size();
    txq.push_back(8'h77);
    wait_low(1, "fl_tx_start");
    bus.tx_flush = 1'b1;
    bus.ft_rxfn  = 1'b0;
    step(1);
    bus.tx_flush = 1'b0;
    wait_low(2, "fl_siwu1_start");
    bus.tx_flush = 1'b1;
    step(1);
    bus.tx_flush = 1'b0;
    wait_log(base + 4, "fl_done");
    bus.ft_rxfn = 1'b1;
    chk("fl_k0", tr_q[base].kind, K_TX);
    chk("fl_tx_data", tr_q[base].data, 8'h77);
    chk("fl_k1", tr_q[base + 1].kind, K_SW);
    chk("fl_sw1_len", tr_q[base + 1].len, 4);
    chk("fl_sw1_gap", tr_q[base + 1].start - (tr_q[base].start + tr_q[base].len), 9);
    chk("fl_k2", tr_q[base + 2].kind, K_SW);
    chk("fl_sw2_len", tr_q[base + 2].len, 4);
    chk("fl_sw2_gap", tr_q[base + 2].start - (tr_q[base + 1].start + tr_q[base + 1].len), 9);
    chk("fl_k3", tr_q[base + 3].kind, K_RX);
    chk("fl_rx_gap", tr_q[base + 3].start - (tr_q[base + 2].start + tr_q[base + 2].len), 9);
    step(15);

    // ---- reset in the 2nd WR# cycle, with an unread rx word held ----
    bus.rx_ready = 1'b0;
    bus.ft_rxfn  = 1'b0;
    step(4);
    txq.push_back(8'h99);
    wait_low(1, "mr_tx_start");
    bus.ft_rxfn = 1'b1;
    chk("mr_rx_valid_before", bus.rx_valid, 1);
    step(1);
    rst = 1'b1;
    step(1);
    chk("mr_wrn", bus.ft_wrn, 1);
    chk("mr_doe", bus.ft_doe, 0);
    chk("mr_dout", bus.ft_dout, 0);
    chk("mr_rx_valid", bus.rx_valid, 0);
    txq.push_back(8'hAB);
    step(1);
    rst = 1'b0;
    r = cyc;
    nb = tr_q.size();
    chk("mr_abort_kind", tr_q[nb - 1].kind, K_TX);
    chk("mr_abort_len", tr_q[nb - 1].len, 2);
    wait_log(nb + 1, "mr_next_done");
    chk("mr_next_start", tr_q[nb].start - r, 4);
    chk("mr_next_data", tr_q[nb].data, 8'hAB);
    chk("mr_next_len", tr_q[nb].len, 4);
    bus.rx_ready = 1'b1;
    step(15);

    chk("no_overlap", ovl_bad, 0);
    chk("doe_during_wr", doe_bad, 0);
    chk("dout_stable", dout_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
